multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 64 ++++++
 rtl/multicycle_ctrl_decode.sv | 68 ++++++
 rtl/multicycle_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, ALU functions,
// branch conditions, the PSW layout and the decoded control-word layout.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_LHI = 5'b00001;
    localparam logic [4:0] OP_LLI = 5'b00010;
    localparam logic [4:0] OP_LDR = 5'b00011;
    localparam logic [4:0] OP_STR = 5'b00100;
    localparam logic [4:0] OP_ALU = 5'b00101;
    localparam logic [4:0] OP_CMP = 5'b00110;
    localparam logic [4:0] OP_B   = 5'b01000;
    localparam logic [4:0] OP_HLT = 5'b11111;

    // ALU function field doubles as the {ALUop, Flag} pair.
    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_ADC = 2'b01;
    localparam logic [1:0] FN_SUB = 2'b10;
    localparam logic [1:0] FN_SBC = 2'b11;

    localparam logic [2:0] BC_AL = 3'b000;
    localparam logic [2:0] BC_EQ = 3'b001;
    localparam logic [2:0] BC_NE = 3'b010;
    localparam logic [2:0] BC_MI = 3'b011;
    localparam logic [2:0] BC_CS = 3'b100;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
    } psw_t;

    typedef struct packed {
        logic ir_write;
        logic pc_write;
        logic pc_src;
        logic mem_read;
        logic mem_write;
        logic wb_rf;
        logic wb_resource;
        logic rb_resource;
        logic oprand_b;
        logic li;
        logic buff_out_r;
        logic alu_op;
        logic flag;
        logic illegal;
    } ctrl_t;

    function automatic logic is_legal(input logic [4:0] op);
        return op inside {OP_NOP, OP_LHI, OP_LLI, OP_LDR, OP_STR,
                          OP_ALU, OP_CMP, OP_B, OP_HLT};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational control decoder: maps (state, instruction fields, PSW, MemReady)
// to the datapath control word.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [4:0]  op,
    input  logic [2:0]  cond,
    input  logic [1:0]  fn,
    input  psw_t        psw,
    input  logic        mem_ready,
    output ctrl_t       ctrl
);

    logic taken;

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            BC_AL:   taken = 1'b1;
            BC_EQ:   taken = psw.z;
            BC_NE:   taken = !psw.z;
            BC_MI:   taken = psw.n;
            BC_CS:   taken = psw.c;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every field gets a default before the case so no path can infer a latch.
        ctrl = '0;
        unique case (state)
            S_IF: begin
                ctrl.mem_read = 1'b1;
                ctrl.ir_write = mem_ready;
                ctrl.pc_write = mem_ready;
            end
            S_ID: begin
                ctrl.rb_resource = op inside {OP_LHI, OP_STR, OP_CMP};
                ctrl.illegal     = !is_legal(op);
            end
            S_EXE: begin
                ctrl.buff_out_r = op inside {OP_ALU, OP_LHI, OP_LLI, OP_LDR, OP_STR};
                ctrl.oprand_b   = op inside {OP_LDR, OP_STR};
                ctrl.li         = (op == OP_LHI);
                if (op == OP_ALU) begin
                    {ctrl.alu_op, ctrl.flag} = fn;
                end else if (op == OP_CMP) begin
                    {ctrl.alu_op, ctrl.flag} = FN_SUB;
                end
                if (op == OP_B) begin
                    ctrl.pc_write = taken;
                    ctrl.pc_src   = taken;
                end
            end
            S_MEM: begin
                ctrl.mem_read  = (op == OP_LDR);
                ctrl.mem_write = (op == OP_STR);
            end
            S_WB: begin
                ctrl.wb_rf       = 1'b1;
                ctrl.wb_resource = (op == OP_LDR);
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor controller: IF/ID/EXE/MEM/WB/HALT sequencer plus the
// PSW flag register; output decoding lives in ctrl_decode.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [15:0] IR,
    input  logic        MemReady,
    input  logic        N,
    input  logic        Z,
    input  logic        C,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCsrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        WBRF,
    output logic        WBresource,
    output logic        RBresource,
    output logic        OprandB,
    output logic        LI,
    output logic        Buff_OutR,
    output logic        ALUop,
    output logic        Flag,
    output logic        PSW_C,
    output logic        Halted,
    output logic        Illegal
);

    state_t     state;
    state_t     state_nxt;
    psw_t       psw;
    ctrl_t      dec;
    ctrl_t      ctrl;
    logic [4:0] op;

    assign op = IR[15:11];

    ctrl_decode u_decode (
        .state     (state),
        .op        (op),
        .cond      (IR[10:8]),
        .fn        (IR[1:0]),
        .psw       (psw),
        .mem_ready (MemReady),
        .ctrl      (dec)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IF:  if (MemReady) state_nxt = S_ID;
            S_ID: begin
                if (op == OP_HLT)                          state_nxt = S_HALT;
                else if (!is_legal(op))                    state_nxt = HALT_ON_ILLEGAL ? S_HALT : S_IF;
                else if (op == OP_NOP)                     state_nxt = S_IF;
                else                                       state_nxt = S_EXE;
            end
            S_EXE: begin
                if (op inside {OP_ALU, OP_LHI, OP_LLI})    state_nxt = S_WB;
                else if (op inside {OP_LDR, OP_STR})       state_nxt = S_MEM;
                else                                       state_nxt = S_IF;
            end
            S_MEM: if (MemReady) state_nxt = (op == OP_LDR) ? S_WB : S_IF;
            S_WB:  state_nxt = S_IF;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IF;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IF;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            psw <= '0;
        end else if (state == S_EXE && (op == OP_ALU || op == OP_CMP)) begin
            psw <= '{n: N, z: Z, c: C};
        end
    end

    // Reset parks the FSM in IF, whose fetch strobes must stay silent until release.
    assign ctrl = Reset ? '0 : dec;

    assign IRWrite    = ctrl.ir_write;
    assign PCWrite    = ctrl.pc_write;
    assign PCsrc      = ctrl.pc_src;
    assign MemRead    = ctrl.mem_read;
    assign MemWrite   = ctrl.mem_write;
    assign WBRF       = ctrl.wb_rf;
    assign WBresource = ctrl.wb_resource;
    assign RBresource = ctrl.rb_resource;
    assign OprandB    = ctrl.oprand_b;
    assign LI         = ctrl.li;
    assign Buff_OutR  = ctrl.buff_out_r;
    assign ALUop      = ctrl.alu_op;
    assign Flag       = ctrl.flag;
    assign Illegal    = ctrl.illegal;
    assign PSW_C      = psw.c;
    assign Halted     = (state == S_HALT);

endmodule
